regfile_wr_sched: RTL and testbench

Write-port scheduler for the processor's 8-entry register file (W=8, A=3), which has a single write port.
- Shares that port between the core write-back path and a secondary loader (test/boot loader that seeds registers and the LFSR via RegDest).
- Sequences a hardware clear of all registers after reset and on demand.
- Drives the register file's RegWrite, RegDest, Waddr and DataIn directly.

---
 rtl/regfile_ctrl_pkg.sv | 22 ++
 rtl/regfile_wr_sched_starve.sv | 47 ++++
 rtl/regfile_wr_sched.sv | 156 +++++++++++++++
 tb/tb_regfile_wr_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
//   sched_state_t : scheduler FSM states (hardware clear / normal run)
//   grant_t       : which requester owns the write port this cycle
//   DEST_*        : RegDest encodings understood by the register file
package regfile_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_LD   = 2'd2,
    GNT_CLR  = 2'd3
  } grant_t;

  localparam logic [1:0] DEST_REG  = 2'b00;
  localparam logic [1:0] DEST_LFSR = 2'b01;

endpackage

// File: rtl/regfile_wr_sched_starve.sv
// Loader starvation counter.
// Counts consecutive cycles in which the loader was blocked and raises
// force_o once the count reaches STARVE, so the loader wins the next grant.
//   Clk, Reset_n : clock, synchronous active-low reset
//   inc          : loader blocked this cycle
//   clr          : loader granted, loader idle, or clear sequence starting
//   force_o      : starvation limit reached
module starve_counter #(
  parameter int STARVE = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic inc,
  input  logic clr,
  output logic force_o
);

  localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment; increment saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for a single-write-port register file.
// Shares the port between the core write-back path and a secondary loader,
// and sequences a hardware clear of every register after reset or on demand.
//   Clk, Reset_n         : clock, synchronous active-low reset
//   CoreWrEn/Dest/Addr/Data, CoreStall : core write-back request and stall
//   LdValid/Dest/Addr/Data, LdReady    : loader valid/ready request
//   ClearReq, ClearBusy  : clear start pulse and clear-in-progress flag
//   RegWrite/RegDest/Waddr/DataIn : register file write port (combinational)
module regfile_wr_sched
  import regfile_ctrl_pkg::*;
#(
  parameter int W      = 8,
  parameter int A      = 3,
  parameter int STARVE = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         CoreWrEn,
  input  logic [1:0]   CoreDest,
  input  logic [A-1:0] CoreAddr,
  input  logic [W-1:0] CoreData,
  output logic         CoreStall,
  input  logic         LdValid,
  input  logic [1:0]   LdDest,
  input  logic [A-1:0] LdAddr,
  input  logic [W-1:0] LdData,
  output logic         LdReady,
  input  logic         ClearReq,
  output logic         ClearBusy,
  output logic         RegWrite,
  output logic [1:0]   RegDest,
  output logic [A-1:0] Waddr,
  output logic [W-1:0] DataIn
);

  localparam logic [A-1:0] CLR_LAST = '1;

  sched_state_t state_q, state_d;
  logic [A-1:0] clr_cnt_q, clr_cnt_d;
  grant_t       grant_s;
  logic         force_s;
  logic         starve_inc_s;
  logic         starve_clr_s;

  // State and clear-address registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: CLEAR walks every address once; ClearReq is only heard in RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + A'(1);
        end
      end
      ST_RUN: begin
        if (ClearReq) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else begin
          state_d   = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Grant selection and write-port drive. A starved loader overrides the
  // core; otherwise the core has priority. The same-cycle RUN grant still
  // completes when ClearReq arrives.
  always_comb begin
    grant_s   = GNT_NONE;
    RegWrite  = 1'b0;
    RegDest   = DEST_REG;
    Waddr     = '0;
    DataIn    = '0;
    LdReady   = 1'b0;
    ClearBusy = 1'b0;
    if (!Reset_n) begin
      grant_s = GNT_NONE;
    end else begin
      case (state_q)
        ST_CLEAR: grant_s = GNT_CLR;
        ST_RUN: begin
          if (LdValid && force_s) begin
            grant_s = GNT_LD;
          end else if (CoreWrEn) begin
            grant_s = GNT_CORE;
          end else if (LdValid) begin
            grant_s = GNT_LD;
          end else begin
            grant_s = GNT_NONE;
          end
        end
        default: grant_s = GNT_NONE;
      endcase
      ClearBusy = (state_q == ST_CLEAR);
    end
    case (grant_s)
      GNT_CORE: begin
        RegWrite = 1'b1;
        RegDest  = CoreDest;
        Waddr    = CoreAddr;
        DataIn   = CoreData;
      end
      GNT_LD: begin
        RegWrite = 1'b1;
        RegDest  = LdDest;
        Waddr    = LdAddr;
        DataIn   = LdData;
        LdReady  = 1'b1;
      end
      GNT_CLR: begin
        RegWrite = 1'b1;
        RegDest  = DEST_REG;
        Waddr    = clr_cnt_q;
        DataIn   = '0;
      end
      default: begin
        RegWrite = 1'b0;
      end
    endcase
    CoreStall = CoreWrEn && (grant_s != GNT_CORE);
  end

  // Starvation only accrues while running; a pending clear restarts it.
  assign starve_inc_s = Reset_n && (state_q == ST_RUN) && LdValid && !LdReady;
  assign starve_clr_s = !LdValid || LdReady || ((state_q == ST_RUN) && ClearReq);

  starve_counter #(
    .STARVE(STARVE)
  ) u_starve (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (starve_inc_s),
    .clr     (starve_clr_s),
    .force_o (force_s)
  );

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed testbench for regfile_wr_sched with a behavioural register file
// and LFSR-seed model hanging off the write port.
module tb_regfile_wr_sched;
  import regfile_ctrl_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       CoreWrEn;
  logic [1:0] CoreDest;
  logic [2:0] CoreAddr;
  logic [7:0] CoreData;
  logic       CoreStall;
  logic       LdValid;
  logic [1:0] LdDest;
  logic [2:0] LdAddr;
  logic [7:0] LdData;
  logic       LdReady;
  logic       ClearReq;
  logic       ClearBusy;
  logic       RegWrite;
  logic [1:0] RegDest;
  logic [2:0] Waddr;
  logic [7:0] DataIn;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [8];
  logic [6:0] lfsr;

  regfile_wr_sched #(.W(8), .A(3), .STARVE(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .CoreWrEn(CoreWrEn), .CoreDest(CoreDest), .CoreAddr(CoreAddr),
    .CoreData(CoreData), .CoreStall(CoreStall),
    .LdValid(LdValid), .LdDest(LdDest), .LdAddr(LdAddr), .LdData(LdData),
    .LdReady(LdReady), .ClearReq(ClearReq), .ClearBusy(ClearBusy),
    .RegWrite(RegWrite), .RegDest(RegDest), .Waddr(Waddr), .DataIn(DataIn)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file / LFSR model driven by the write port.
  always @(posedge Clk) begin
    if (RegWrite) begin
      if (RegDest == DEST_REG) mem[Waddr] <= DataIn;
      else if (RegDest == DEST_LFSR) lfsr <= DataIn[6:0];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; CoreWrEn = 1'b1; CoreDest = 2'b00; CoreAddr = 3'd0; CoreData = 8'h00;
    LdValid = 1'b0; LdDest = 2'b00; LdAddr = 3'd0; LdData = 8'h00; ClearReq = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({RegWrite, LdReady, ClearBusy, CoreStall, RegDest, Waddr, DataIn} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'd0, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_outputs: got we=%b rdy=%b busy=%b stall=%b dest=%b wa=%0d d=%h want 0 0 0 1 00 0 00",
               RegWrite, LdReady, ClearBusy, CoreStall, RegDest, Waddr, DataIn);
    end
    tick();
    CoreWrEn = 1'b0;
    Reset_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if ({RegWrite, RegDest, Waddr, DataIn, ClearBusy, LdReady} !==
          {1'b1, 2'b00, 3'(i), 8'h00, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL reset_clear_%0d: got we=%b dest=%b wa=%0d d=%h busy=%b rdy=%b want 1 00 %0d 00 1 0",
                 i, RegWrite, RegDest, Waddr, DataIn, ClearBusy, LdReady, i);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({ClearBusy, RegWrite, Waddr, DataIn} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_idle: got busy=%b we=%b wa=%0d d=%h want 0 0 0 00",
               ClearBusy, RegWrite, Waddr, DataIn);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[i] !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_mem_%0d: got %h want 00", i, mem[i]);
      end
    end
  endtask

  task automatic test_core_write();
    tick();
    CoreWrEn = 1'b1; CoreDest = 2'b00; CoreAddr = 3'd3; CoreData = 8'hA5; LdValid = 1'b0;
    #1;
    n_checks++;
    if ({RegWrite, RegDest, Waddr, DataIn, CoreStall} !== {1'b1, 2'b00, 3'd3, 8'hA5, 1'b0}) begin
      n_errors++;
      $display("FAIL core_write: got we=%b dest=%b wa=%0d d=%h stall=%b want 1 00 3 a5 0",
               RegWrite, RegDest, Waddr, DataIn, CoreStall);
    end
    tick();
    CoreWrEn = 1'b0;
    #1;
    n_checks++;
    if (mem[3] !== 8'hA5) begin
      n_errors++;
      $display("FAIL core_mem3: got %h want a5", mem[3]);
    end
  endtask

  task automatic test_starve();
    tick();
    CoreWrEn = 1'b1; CoreDest = 2'b00; CoreAddr = 3'd1; CoreData = 8'h77;
    LdValid = 1'b1; LdDest = 2'b00; LdAddr = 3'd5; LdData = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({LdReady, CoreStall, Waddr, DataIn} !== {1'b0, 1'b0, 3'd1, 8'h77}) begin
        n_errors++;
        $display("FAIL starve_block_%0d: got rdy=%b stall=%b wa=%0d d=%h want 0 0 1 77",
                 i, LdReady, CoreStall, Waddr, DataIn);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({RegWrite, LdReady, CoreStall, Waddr, DataIn} !== {1'b1, 1'b1, 1'b1, 3'd5, 8'h3C}) begin
      n_errors++;
      $display("FAIL starve_force: got we=%b rdy=%b stall=%b wa=%0d d=%h want 1 1 1 5 3c",
               RegWrite, LdReady, CoreStall, Waddr, DataIn);
    end
    tick();
    LdAddr = 3'd6; LdData = 8'h99;
    #1;
    n_checks++;
    if ({LdReady, CoreStall, Waddr} !== {1'b0, 1'b0, 3'd1}) begin
      n_errors++;
      $display("FAIL starve_reset_cnt: got rdy=%b stall=%b wa=%0d want 0 0 1",
               LdReady, CoreStall, Waddr);
    end
    tick();
    LdValid = 1'b0; CoreWrEn = 1'b0;
    #1;
    n_checks++;
    if ({mem[5], mem[1], RegWrite} !== {8'h3C, 8'h77, 1'b0}) begin
      n_errors++;
      $display("FAIL starve_mem: got m5=%h m1=%h we=%b want 3c 77 0", mem[5], mem[1], RegWrite);
    end
  endtask

  task automatic test_lfsr_seed();
    tick();
    CoreWrEn = 1'b0; LdValid = 1'b1; LdDest = 2'b01; LdAddr = 3'd7; LdData = 8'h5A;
    #1;
    n_checks++;
    if ({RegWrite, RegDest, DataIn, LdReady} !== {1'b1, 2'b01, 8'h5A, 1'b1}) begin
      n_errors++;
      $display("FAIL lfsr_grant: got we=%b dest=%b d=%h rdy=%b want 1 01 5a 1",
               RegWrite, RegDest, DataIn, LdReady);
    end
    tick();
    LdValid = 1'b0; LdDest = 2'b00;
    #1;
    n_checks++;
    if ({lfsr, mem[7]} !== {7'h5A, 8'h00}) begin
      n_errors++;
      $display("FAIL lfsr_load: got lfsr=%h m7=%h want 5a 00", lfsr, mem[7]);
    end
  endtask

  task automatic test_clear_req();
    tick();
    CoreWrEn = 1'b1; CoreDest = 2'b00; CoreAddr = 3'd2; CoreData = 8'h11; ClearReq = 1'b1;
    #1;
    n_checks++;
    if ({RegWrite, Waddr, DataIn, CoreStall, ClearBusy} !== {1'b1, 3'd2, 8'h11, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL clrreq_core: got we=%b wa=%0d d=%h stall=%b busy=%b want 1 2 11 0 0",
               RegWrite, Waddr, DataIn, CoreStall, ClearBusy);
    end
    tick();
    ClearReq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0) begin
        n_checks++;
        if (mem[2] !== 8'h11) begin
          n_errors++;
          $display("FAIL clrreq_mem2_written: got %h want 11", mem[2]);
        end
      end
      n_checks++;
      if ({ClearBusy, CoreStall, RegWrite, Waddr, DataIn} !== {1'b1, 1'b1, 1'b1, 3'(i), 8'h00}) begin
        n_errors++;
        $display("FAIL clrreq_clear_%0d: got busy=%b stall=%b we=%b wa=%0d d=%h want 1 1 1 %0d 00",
                 i, ClearBusy, CoreStall, RegWrite, Waddr, DataIn, i);
      end
      if (i == 7) CoreWrEn = 1'b0;
      tick();
    end
    #1;
    n_checks++;
    if ({ClearBusy, RegWrite, mem[2], mem[3]} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL clrreq_done: got busy=%b we=%b m2=%h m3=%h want 0 0 00 00",
               ClearBusy, RegWrite, mem[2], mem[3]);
    end
  endtask

  task automatic test_reset_mid_clear();
    tick();
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_checks++;
    if ({ClearBusy, Waddr} !== {1'b1, 3'd4}) begin
      n_errors++;
      $display("FAIL midclr_pos: got busy=%b wa=%0d want 1 4", ClearBusy, Waddr);
    end
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({RegWrite, ClearBusy, Waddr, DataIn, LdReady, CoreStall} !==
        {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL midclr_reset: got we=%b busy=%b wa=%0d d=%h rdy=%b stall=%b want 0 0 0 00 0 0",
               RegWrite, ClearBusy, Waddr, DataIn, LdReady, CoreStall);
    end
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if ({RegWrite, ClearBusy, Waddr} !== {1'b1, 1'b1, 3'(i)}) begin
        n_errors++;
        $display("FAIL midclr_restart_%0d: got we=%b busy=%b wa=%0d want 1 1 %0d",
                 i, RegWrite, ClearBusy, Waddr, i);
      end
      tick();
    end
    #1;
    n_checks++;
    if (ClearBusy !== 1'b0) begin
      n_errors++;
      $display("FAIL midclr_done: got busy=%b want 0", ClearBusy);
    end
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_starve();
    test_lfsr_seed();
    test_clear_req();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
